// File: rtl/color_detect_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | color_detect_pkg : shared state codes, LED layout, default parameters|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package color_detect_pkg;

  localparam int DEF_N_SW        = 3;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DB_CYCLES   = 65536;
  localparam int DEF_CFG_TIMEOUT = 1048576;
  localparam int DEF_CFG_RETRIES = 3;

  typedef enum logic [2:0] {
    ST_CFG_START = 3'd0,
    ST_CFG_WAIT  = 3'd1,
    ST_ACTIVE    = 3'd2,
    ST_FLUSH     = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam int LED_STATE_LSB = 0;
  localparam int LED_STATE_W   = 3;
  localparam int LED_ERR_BIT   = 3;
  localparam int LED_FE_LSB    = 4;
  localparam int LED_FE_W      = 4;

  function automatic logic [7:0] pack_leds(input state_e st, input logic err,
                                           input logic [LED_FE_W-1:0] fe);
    logic [7:0] leds;
    leds = '0;
    leds[LED_STATE_LSB +: LED_STATE_W] = st;
    leds[LED_ERR_BIT]                  = err;
    leds[LED_FE_LSB +: LED_FE_W]       = fe;
    return leds;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_mode_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_mode_ctrl_if : frame/config handshake and filter control bundle |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface pipe_mode_ctrl_if
  import color_detect_pkg::*;
#(
  parameter int N_SW = DEF_N_SW
);
  logic            i_sof;
  logic [N_SW-1:0] i_sw;
  logic            i_cfg_done;
  logic            o_cfg_start;
  logic            o_pipe_flush;
  logic [N_SW-1:0] o_filter_en;
  logic            o_cfg_error;
  logic [7:0]      o_status_leds;

  modport slave (
    input  i_sof, i_sw, i_cfg_done,
    output o_cfg_start, o_pipe_flush, o_filter_en, o_cfg_error, o_status_leds
  );

  modport master (
    output i_sof, i_sw, i_cfg_done,
    input  o_cfg_start, o_pipe_flush, o_filter_en, o_cfg_error, o_status_leds
  );
endinterface
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sw_debounce : one switch channel, synchroniser plus hold debouncer   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sw_debounce
  import color_detect_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
  input  logic i_sysclk,
  input  logic i_rstn,
  input  logic i_sw_async,
  output logic o_db
);

  localparam int              CNT_W    = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_out;
  logic                   db_q, db_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // The counter tallies disagreeing cycles; the last one flips db and restarts it.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], i_sw_async};
    sync_out = sync_q[SYNC_STAGES-1];
    db_d     = db_q;
    cnt_d    = '0;
    if (sync_out != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync_out;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_db = db_q;

endmodule
`default_nettype wire

// File: rtl/pipe_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_mode_ctrl : camera config sequencing and frame-aligned filters  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipe_mode_ctrl
  import color_detect_pkg::*;
#(
  parameter int N_SW        = DEF_N_SW,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int CFG_TIMEOUT = DEF_CFG_TIMEOUT,
  parameter int CFG_RETRIES = DEF_CFG_RETRIES
) (
  input  logic            i_sysclk,
  input  logic            i_rstn,
  pipe_mode_ctrl_if.slave bus
);

  localparam int               TMO_W    = $clog2(CFG_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CFG_TIMEOUT - 1);
  localparam int               ATT_W    = $clog2(CFG_RETRIES + 1);
  localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(CFG_RETRIES);
  localparam int               FE_LED_W = (N_SW < LED_FE_W) ? N_SW : LED_FE_W;

  logic [N_SW-1:0] db;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    sw_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_sw_debounce (
      .i_sysclk   (i_sysclk),
      .i_rstn     (i_rstn),
      .i_sw_async (bus.i_sw[i]),
      .o_db       (db[i])
    );
  end

  state_e              state_q, state_d;
  logic                cfg_start_q, cfg_start_d;
  logic                flush_q, flush_d;
  logic [N_SW-1:0]     filter_q, filter_d;
  logic                err_q, err_d;
  logic [7:0]          leds_q, leds_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [ATT_W-1:0]    att_q, att_d;
  logic [LED_FE_W-1:0] led_fe;

  // Outputs are derived from the next state so they register alongside it.
  always_comb begin
    state_d     = state_q;
    cfg_start_d = 1'b0;
    filter_d    = filter_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    att_d       = att_q;
    case (state_q)
      ST_CFG_START: begin
        cfg_start_d = 1'b1;
        tmo_d       = '0;
        att_d       = att_q + 1'b1;
        state_d     = ST_CFG_WAIT;
      end
      ST_CFG_WAIT: begin
        if (bus.i_cfg_done) begin
          state_d = ST_ACTIVE;
        end else if (tmo_q == TMO_LAST) begin
          if (att_q < ATT_MAX) begin
            state_d = ST_CFG_START;
          end else begin
            state_d  = ST_FAULT;
            err_d    = 1'b1;
            filter_d = '0;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (db != filter_q) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (bus.i_sof) begin
          filter_d = db;
          state_d  = ST_ACTIVE;
        end
      end
      ST_FAULT: begin
        err_d    = 1'b1;
        filter_d = '0;
      end
      default: state_d = ST_CFG_START;
    endcase

    flush_d                = (state_d == ST_FLUSH);
    led_fe                 = '0;
    led_fe[FE_LED_W-1:0]   = filter_d[FE_LED_W-1:0];
    leds_d                 = pack_leds(state_d, err_d, led_fe);
  end

  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      state_q     <= ST_CFG_START;
      cfg_start_q <= 1'b0;
      flush_q     <= 1'b0;
      filter_q    <= '0;
      err_q       <= 1'b0;
      leds_q      <= '0;
      tmo_q       <= '0;
      att_q       <= '0;
    end else begin
      state_q     <= state_d;
      cfg_start_q <= cfg_start_d;
      flush_q     <= flush_d;
      filter_q    <= filter_d;
      err_q       <= err_d;
      leds_q      <= leds_d;
      tmo_q       <= tmo_d;
      att_q       <= att_d;
    end
  end

  assign bus.o_cfg_start   = cfg_start_q;
  assign bus.o_pipe_flush  = flush_q;
  assign bus.o_filter_en   = filter_q;
  assign bus.o_cfg_error   = err_q;
  assign bus.o_status_leds = leds_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_mode_ctrl : directed self-checking bench for pipe_mode_ctrl  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pipe_mode_ctrl;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipe_mode_ctrl_if #(.N_SW(3)) bus ();

  pipe_mode_ctrl #(
    .N_SW        (3),
    .SYNC_STAGES (2),
    .DB_CYCLES   (4),
    .CFG_TIMEOUT (16),
    .CFG_RETRIES (3)
  ) dut (
    .i_sysclk (clk),
    .i_rstn   (rstn),
    .bus      (bus)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sof_pulse();
    bus.i_sof = 1'b1;
    tick();
    bus.i_sof = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    int low_cnt;
    int hi_cnt;
    int p_cnt;
    int first_err;
    int pidx [4];

    bus.i_sof      = 1'b0;
    bus.i_sw       = 3'b000;
    bus.i_cfg_done = 1'b0;
    rstn           = 1'b0;
    repeat (3) tick();

    check("rst_cfg_start", bus.o_cfg_start, 0);
    check("rst_flush", bus.o_pipe_flush, 0);
    check("rst_filter", bus.o_filter_en, 0);
    check("rst_err", bus.o_cfg_error, 0);
    check("rst_leds", bus.o_status_leds, 8'h00);

    // Configuration completes on the first attempt.
    rstn = 1'b1;
    tick();
    check("first_pulse", bus.o_cfg_start, 1);
    check("leds_cfg_wait", bus.o_status_leds, 8'h01);
    pulses = 1;
    repeat (4) begin
      tick();
      if (bus.o_cfg_start) pulses++;
    end
    bus.i_cfg_done = 1'b1;
    tick();
    bus.i_cfg_done = 1'b0;
    if (bus.o_cfg_start) pulses++;
    check("state_active", bus.o_status_leds[2:0], 3'd2);
    repeat (20) begin
      tick();
      if (bus.o_cfg_start) pulses++;
    end
    check("single_pulse", pulses, 1);
    check("leds_active", bus.o_status_leds, 8'h02);

    // Switch change: flush after sync + debounce + fsm latency.
    bus.i_sw = 3'b101;
    repeat (6) tick();
    check("flush_not_early", bus.o_pipe_flush, 0);
    tick();
    check("flush_start", bus.o_pipe_flush, 1);
    check("leds_flush", bus.o_status_leds[2:0], 3'd3);
    low_cnt = 0;
    repeat (9) begin
      tick();
      if (!bus.o_pipe_flush) low_cnt++;
    end
    check("flush_held", low_cnt, 0);
    sof_pulse();
    check("filter_101", bus.o_filter_en, 3'b101);
    check("flush_drop", bus.o_pipe_flush, 0);
    check("leds_101", bus.o_status_leds, 8'h52);
    tick();
    check("no_reflush", bus.o_pipe_flush, 0);

    // Three-cycle glitch on bit 0 must be rejected.
    bus.i_sw = 3'b100;
    repeat (3) tick();
    bus.i_sw = 3'b101;
    hi_cnt = 0;
    repeat (12) begin
      tick();
      if (bus.o_pipe_flush) hi_cnt++;
    end
    check("glitch_no_flush", hi_cnt, 0);
    check("glitch_filter", bus.o_filter_en, 3'b101);

    // Switch moves during flush; the value at sof is applied, flush continuous.
    bus.i_sw = 3'b001;
    repeat (7) tick();
    check("flush2_start", bus.o_pipe_flush, 1);
    repeat (2) tick();
    bus.i_sw = 3'b011;
    low_cnt = 0;
    repeat (10) begin
      tick();
      if (!bus.o_pipe_flush) low_cnt++;
    end
    check("flush2_continuous", low_cnt, 0);
    check("filter_hold_in_flush", bus.o_filter_en, 3'b101);
    sof_pulse();
    check("filter_011", bus.o_filter_en, 3'b011);
    check("flush2_drop", bus.o_pipe_flush, 0);
    hi_cnt = 0;
    repeat (10) begin
      tick();
      if (bus.o_pipe_flush) hi_cnt++;
    end
    check("flush2_no_reflush", hi_cnt, 0);

    // Reset in the middle of a flush.
    bus.i_sw = 3'b111;
    repeat (7) tick();
    check("flush3_start", bus.o_pipe_flush, 1);
    rstn = 1'b0;
    tick();
    check("midrst_cfg_start", bus.o_cfg_start, 0);
    check("midrst_flush", bus.o_pipe_flush, 0);
    check("midrst_filter", bus.o_filter_en, 0);
    check("midrst_err", bus.o_cfg_error, 0);
    check("midrst_leds", bus.o_status_leds, 8'h00);
    tick();
    rstn = 1'b1;
    tick();
    check("postrst_pulse", bus.o_cfg_start, 1);
    check("postrst_leds", bus.o_status_leds, 8'h01);

    // No cfg_done: three attempts then fault.
    p_cnt     = 1;
    first_err = -1;
    for (int k = 0; k < 4; k++) pidx[k] = -1;
    pidx[0] = 0;
    for (int t = 1; t <= 60; t++) begin
      tick();
      if (bus.o_cfg_start) begin
        if (p_cnt < 4) pidx[p_cnt] = t;
        p_cnt++;
      end
      if (bus.o_cfg_error && first_err < 0) first_err = t;
    end
    check("retry_count", p_cnt, 3);
    check("retry2_at", pidx[1], 17);
    check("retry3_at", pidx[2], 34);
    check("fault_at", first_err, 50);
    check("fault_leds", bus.o_status_leds, 8'h0C);
    check("fault_flush", bus.o_pipe_flush, 0);
    check("fault_filter", bus.o_filter_en, 0);
    bus.i_cfg_done = 1'b1;
    tick();
    bus.i_cfg_done = 1'b0;
    check("fault_sticky_leds", bus.o_status_leds, 8'h0C);
    check("fault_no_pulse", bus.o_cfg_start, 0);

    // Switch change during configuration is deferred to the first ACTIVE cycle.
    rstn     = 1'b0;
    bus.i_sw = 3'b000;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    bus.i_sw = 3'b010;
    repeat (10) tick();
    check("defer_no_flush_wait", bus.o_pipe_flush, 0);
    bus.i_cfg_done = 1'b1;
    tick();
    bus.i_cfg_done = 1'b0;
    check("defer_active_leds", bus.o_status_leds, 8'h02);
    tick();
    check("defer_flush", bus.o_pipe_flush, 1);
    check("defer_flush_leds", bus.o_status_leds, 8'h03);
    sof_pulse();
    check("defer_filter", bus.o_filter_en, 3'b010);
    check("defer_final_leds", bus.o_status_leds, 8'h22);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_mode_ctrl.md
PIPE_MODE_CTRL -- requirements
Module: pipe_mode_ctrl

Interface
REQ-001 SHALL have parameter N_SW, default 3: number of filter-enable switch channels, range 1..5.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser flops per switch, minimum 2.
REQ-003 SHALL have parameter DB_CYCLES, default 65536: consecutive cycles a new switch level must hold before acceptance, minimum 2.
REQ-004 SHALL have parameter CFG_TIMEOUT, default 1048576: cycles to wait for i_cfg_done before a config retry.
REQ-005 SHALL have parameter CFG_RETRIES, default 3: config attempts before declaring an error.
REQ-006 i_sysclk  input  1  system clock; all logic on its rising edge.
REQ-007 i_rstn  input  1  reset, synchronous, active-low.
REQ-008 i_sof  input  1  start-of-frame pulse from the capture pipeline.
REQ-009 i_sw  input  N_SW  raw asynchronous filter-enable switches.
REQ-010 i_cfg_done  input  1  camera-configuration-complete pulse.
REQ-011 o_cfg_start  output  1  one-cycle camera-configuration start pulse.
REQ-012 o_pipe_flush  output  1  pipeline flush request, level.
REQ-013 o_filter_en  output  N_SW  applied filter enables, frame-aligned.
REQ-014 o_cfg_error  output  1  sticky flag: configuration failed after all retries.
REQ-015 o_status_leds  output  8  status display.

Function
REQ-016 Each i_sw bit SHALL pass through a SYNC_STAGES-deep synchroniser, then a per-channel debouncer.
REQ-017 The debouncer SHALL update db[i] to the synchronised value after exactly DB_CYCLES consecutive cycles of disagreement; any agreeing cycle SHALL clear that channel's counter.
REQ-018 The state machine SHALL have states CFG_START, CFG_WAIT, ACTIVE, FLUSH and FAULT.
REQ-019 CFG_START: assert o_cfg_start for one cycle, clear the timeout counter, increment the attempt count, then go to CFG_WAIT.
REQ-020 CFG_WAIT: i_cfg_done SHALL go to ACTIVE; a timeout at CFG_TIMEOUT cycles SHALL go to CFG_START if attempts < CFG_RETRIES, else to FAULT.
REQ-021 FAULT SHALL set o_cfg_error and remain there until reset; o_filter_en holds 0 and o_pipe_flush holds 0.
REQ-022 ACTIVE: if db != o_filter_en, go to FLUSH next cycle; o_pipe_flush SHALL be 1 from the cycle FLUSH is entered.
REQ-023 FLUSH: o_pipe_flush SHALL stay 1. On i_sof, o_filter_en <= current db, the state returns to ACTIVE, and o_pipe_flush drops the following cycle.
REQ-024 A switch change during FLUSH SHALL NOT extend or restart the flush; the db value sampled on the i_sof cycle is the one applied.
REQ-025 If db differs from o_filter_en again after return to ACTIVE, FLUSH SHALL re-enter on the next cycle.
REQ-026 Switch changes during CFG_START or CFG_WAIT SHALL be deferred; the comparison in REQ-022 SHALL apply on the first ACTIVE cycle.
REQ-027 i_sof outside FLUSH and i_cfg_done outside CFG_WAIT SHALL be ignored.
REQ-028 o_status_leds SHALL be: [2:0] state code (CFG_START=0, CFG_WAIT=1, ACTIVE=2, FLUSH=3, FAULT=4), [3] o_cfg_error, [7:4] o_filter_en zero-padded or truncated to 4 bits; all outputs SHALL be registered.

Reset
REQ-029 On reset: state CFG_START; o_cfg_start=0, o_pipe_flush=0, o_filter_en=0, o_cfg_error=0, o_status_leds=0; synchronisers, db, counters and attempt count all 0.
REQ-030 Reset asserted mid-flush or mid-configuration SHALL abort the operation; after release, o_cfg_start SHALL pulse on the first clock edge.

Structure
REQ-031 State encodings, LED bit positions and parameter defaults SHALL live in the shared package color_detect_pkg.
REQ-032 The synchroniser plus debouncer SHALL be one sub-module, sw_debounce, parameterised by SYNC_STAGES and DB_CYCLES and instantiated N_SW times via generate.

Verification (N_SW=3, SYNC_STAGES=2, DB_CYCLES=4, CFG_TIMEOUT=16, CFG_RETRIES=3)
REQ-033 Release reset; pulse i_cfg_done 5 cycles later -> exactly one o_cfg_start pulse, state ACTIVE, LEDs[2:0]=2.
REQ-034 Never assert i_cfg_done -> o_cfg_start pulses 3 times, 17 cycles apart; then o_cfg_error=1 and LEDs=8'h0C.
REQ-035 In ACTIVE, i_sw=3'b101 held -> o_pipe_flush=1 starting 2+4+1 cycles later; i_sof 10 cycles after that -> o_filter_en=3'b101, flush drops the next cycle.
REQ-036 A 3-cycle glitch on i_sw[0] -> no flush and o_filter_en unchanged.
REQ-037 i_sw changes 3'b001 to 3'b011 during FLUSH, debounced before i_sof -> o_filter_en=3'b011 and a single continuous flush.
REQ-038 Reset asserted while in FLUSH -> all outputs 0 next cycle; o_cfg_start pulses after release.
